debug_controller: RTL and testbench
===================================

DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 18, the processor word width.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  host command present.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op  input  2  command: 0 NOP, 1 STATUS, 2 DUMP, 3 CONTINUE.
REQ-007 SHALL have port rsp_valid  output  1  response word present.
REQ-008 SHALL have port rsp_ready  input  1  host accepts the word when rsp_valid & rsp_ready.
REQ-009 SHALL have port rsp_data  output  WORD_SIZE  response word.
REQ-010 SHALL have port rsp_last  output  1  marks the final word of a response.
REQ-011 SHALL have port cpu_wait_for_continue  input  1  processor halted on a wait instruction.
REQ-012 SHALL have port cpu_wait_continue_execution  output  1  one-cycle resume pulse to the processor.
REQ-013 SHALL have port cpu_debug_get_param  output  1  freezes the processor and selects debug readout.
REQ-014 SHALL have port cpu_debug_reg_addr  output  4  readout select: 0..7 = r0..r7, 8 = ip.
REQ-015 SHALL have port cpu_debug_data_out  input  WORD_SIZE  combinational readout value from the processor.

Function
REQ-016 SHALL implement the states IDLE, STATUS_SEND, DUMP_READ, DUMP_SEND, CONT_PULSE and RESP_SEND.
REQ-017 NOP SHALL be accepted and produce no response; the controller stays in IDLE.
REQ-018 STATUS SHALL send one word with bit0 = cpu_wait_for_continue, sampled at acceptance, and all other bits 0; rsp_last = 1.
REQ-019 DUMP while cpu_wait_for_continue = 0 SHALL send one error word with all bits 1 and rsp_last = 1.
REQ-020 DUMP while halted SHALL send 9 words in the order r0..r7, ip, with rsp_last = 1 on the ip word only.
REQ-021 DUMP_READ SHALL drive cpu_debug_reg_addr = idx, register cpu_debug_data_out into rsp_data, set rsp_valid, and move to DUMP_SEND.
REQ-022 DUMP_SEND SHALL hold the word until the handshake, then increment idx and return to DUMP_READ, or go to IDLE after idx 8.
REQ-023 Each dump word SHALL be presented with a minimum of 2 cycles per word, i.e. 18 cycles from acceptance to last handshake with rsp_ready held high.
REQ-024 cpu_debug_get_param SHALL be 1 in DUMP_READ and DUMP_SEND and 0 in all other states, so the processor stays frozen for the whole dump.
REQ-025 CONTINUE while halted SHALL drive cpu_wait_continue_execution = 1 for exactly one cycle (CONT_PULSE), then send response word 0 with rsp_last = 1.
REQ-026 CONTINUE while not halted SHALL produce no pulse and send response word 1 with rsp_last = 1.
REQ-027 While rsp_valid = 1 and rsp_ready = 0, rsp_data and rsp_last SHALL stay stable.
REQ-028 cmd_ready SHALL be 0 from acceptance until the final response handshake, so commands never overlap.
REQ-029 A cpu_wait_for_continue change during a dump SHALL NOT abort the dump; the dump completes all 9 words.

Reset
REQ-030 Assertion of reset SHALL immediately force state IDLE and idx 0, including mid-dump or mid-pulse.
REQ-031 During reset, outputs SHALL be rsp_valid 0, rsp_data 0, rsp_last 0, cpu_wait_continue_execution 0, cpu_debug_get_param 0, cpu_debug_reg_addr 0, and cmd_ready 0.
REQ-032 cmd_ready SHALL rise in the first cycle after reset deassertion.

Configuration
REQ-033 With macro DEBUG_CTRL_CONTINUE_COUNTER_EN defined, the controller SHALL keep a WORD_SIZE-bit counter, saturating at all-ones, incremented on each issued resume pulse.
REQ-034 With DEBUG_CTRL_CONTINUE_COUNTER_EN defined, STATUS SHALL send 2 words (status, counter), with rsp_last on the second.
REQ-035 Without the macro, the counter SHALL be absent and STATUS SHALL send 1 word.

Structure
REQ-036 Package debug_controller_pkg SHALL hold the cmd_op enum, the state enum, DUMP_WORDS = 9, IP_SELECT = 8, and ERR_WORD = all-ones.
REQ-037 The block SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-038 Halted CPU with r0..r7 = 1..8 and ip = 0x00123; DUMP with rsp_ready held high -> 9 words 1..8, 0x00123; rsp_last on the 9th only; get_param high throughout.
REQ-039 Running CPU, DUMP -> single word 0x3FFFF with rsp_last = 1; get_param never asserted.
REQ-040 Halted CPU, CONTINUE -> exactly one cycle of cpu_wait_continue_execution = 1, then response 0; running CPU, CONTINUE -> no pulse, response 1.
REQ-041 DUMP with rsp_ready toggling 1 cycle on / 2 cycles off -> words unchanged while stalled, order intact, cmd_ready low until the last handshake.
REQ-042 Reset asserted on the 4th dump word -> all outputs at reset values within the same cycle; a STATUS after release returns 0x00001 while halted.
REQ-043 With DEBUG_CTRL_CONTINUE_COUNTER_EN, 3 CONTINUEs then STATUS -> words 0x00001 and 0x00003, rsp_last on the second.

Source files
------------

// File: rtl/debug_controller_pkg.sv
// debug_controller_pkg: command/state encodings and constants shared by the debug controller.
package debug_controller_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_STATUS, OP_DUMP, OP_CONTINUE} cmd_op_t;
  typedef enum logic [2:0] {IDLE, STATUS_SEND, DUMP_READ, DUMP_SEND, CONT_PULSE, RESP_SEND} state_t;
  localparam int DUMP_WORDS = 9;
  localparam logic [3:0] IP_SELECT = 4'd8;
  localparam logic [63:0] ERR_WORD = '1;
endpackage

// File: rtl/debug_controller.sv
// debug_controller: host command/response bridge to a processor's halt/resume and register readout.
// DEBUG_CTRL_CONTINUE_COUNTER_EN adds a saturating resume counter appended to STATUS responses.
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_last,
  input  logic                 cpu_wait_for_continue,
  output logic                 cpu_wait_continue_execution,
  output logic                 cpu_debug_get_param,
  output logic [3:0]           cpu_debug_reg_addr,
  input  logic [WORD_SIZE-1:0] cpu_debug_data_out
);
  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic                   valid_q, valid_d, last_q, last_d, live_q, hs;
  logic [WORD_SIZE-1:0]   data_q, data_d;
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
  logic [WORD_SIZE-1:0]   cnt_q, cnt_d;
`endif

  assign hs                          = valid_q & rsp_ready;
  assign cmd_ready                   = live_q & (state_q == IDLE);
  assign rsp_valid                   = valid_q;
  assign rsp_data                    = data_q;
  assign rsp_last                    = last_q;
  assign cpu_wait_continue_execution = state_q == CONT_PULSE;
  assign cpu_debug_get_param         = (state_q == DUMP_READ) | (state_q == DUMP_SEND);
  assign cpu_debug_reg_addr          = idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid & cmd_ready) begin
        case (cmd_op_t'(cmd_op))
          OP_STATUS: begin
            state_d = STATUS_SEND;
            valid_d = 1'b1;
            data_d  = WORD_SIZE'(cpu_wait_for_continue);
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
            last_d  = 1'b0;
`else
            last_d  = 1'b1;
`endif
          end
          OP_DUMP: begin
            state_d = cpu_wait_for_continue ? DUMP_READ : RESP_SEND;
            idx_d   = '0;
            valid_d = !cpu_wait_for_continue;
            data_d  = ERR_WORD[WORD_SIZE-1:0];
            last_d  = 1'b1;
          end
          OP_CONTINUE: begin
            state_d = cpu_wait_for_continue ? CONT_PULSE : RESP_SEND;
            valid_d = !cpu_wait_for_continue;
            data_d  = WORD_SIZE'(1);
            last_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      STATUS_SEND: if (hs) begin
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
        state_d = RESP_SEND;
        data_d  = cnt_q;
        last_d  = 1'b1;
`else
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
`endif
      end
      DUMP_READ: begin
        state_d = DUMP_SEND;
        valid_d = 1'b1;
        data_d  = cpu_debug_data_out;
        last_d  = idx_q == IP_SELECT;
      end
      DUMP_SEND: if (hs) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = (idx_q == 4'(DUMP_WORDS - 1)) ? IDLE : DUMP_READ;
        idx_d   = (idx_q == 4'(DUMP_WORDS - 1)) ? 4'd0 : idx_q + 4'd1;
      end
      CONT_PULSE: begin
        state_d = RESP_SEND;
        valid_d = 1'b1;
        data_d  = '0;
        last_d  = 1'b1;
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
        cnt_d   = &cnt_q ? cnt_q : cnt_q + WORD_SIZE'(1);
`endif
      end
      RESP_SEND: if (hs) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      live_q  <= 1'b0;
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      live_q  <= 1'b1;
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: randomized self-checking bench with a response-list reference model.
module tb_debug_controller;
  localparam int W = 18;
  localparam logic [W-1:0] ALL1 = '1;

  logic clock = 0, reset = 0, cmd_valid = 0, rsp_ready = 0, halted = 0;
  logic [1:0] cmd_op = 0;
  logic cmd_ready, rsp_valid, rsp_last, pulse, get_param;
  logic [W-1:0] rsp_data, dbg_out;
  logic [3:0] reg_addr;
  logic [W-1:0] regs [9];
  int total = 0, bad = 0;
  int unsigned cont_cnt = 0;

  always #5 clock = ~clock;
  assign dbg_out = (reg_addr < 4'd9) ? regs[reg_addr] : '0;

  debug_controller #(.WORD_SIZE(W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .cpu_wait_for_continue(halted), .cpu_wait_continue_execution(pulse),
    .cpu_debug_get_param(get_param), .cpu_debug_reg_addr(reg_addr), .cpu_debug_data_out(dbg_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  // Issues one command and checks the whole response against the list the rules predict.
  // mode: 0 ready always high, 1 ready 1-on/2-off, 2 random ready.
  task automatic run_cmd(input logic [1:0] op, input int mode, input bit flip, output int cycles);
    logic [W-1:0] exp_q [$];
    logic [W-1:0] w, pd;
    logic pl;
    bit h, dump, prev_stall, gp_bad, rdy_bad, stab_bad;
    int exp_pulses, pulses, n, t;
    h = halted;
    dump = (op == 2'd2) && h;
    exp_pulses = (op == 2'd3 && h) ? 1 : 0;
    case (op)
      2'd1: begin
        exp_q.push_back(W'(h));
`ifdef DEBUG_CTRL_CONTINUE_COUNTER_EN
        exp_q.push_back(W'(cont_cnt));
`endif
      end
      2'd2: if (h) for (int i = 0; i < 9; i++) exp_q.push_back(regs[i]);
            else exp_q.push_back(ALL1);
      2'd3: exp_q.push_back(h ? W'(0) : W'(1));
      default: ;
    endcase
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clock); t++; end
    cmd_valid = 1; cmd_op = op;
    @(negedge clock);
    cmd_valid = 0;
    cycles = 0; pulses = 0; n = 0;
    prev_stall = 0; gp_bad = 0; rdy_bad = 0; stab_bad = 0; pd = '0; pl = 0;
    if (op == 2'd0) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || pulse !== 1'b0 || get_param !== 1'b0) begin
          bad++;
          $display("FAIL nop: valid=%b ready=%b pulse=%b gp=%b, required 0 1 0 0", rsp_valid, cmd_ready, pulse, get_param);
        end
        @(negedge clock);
      end
      return;
    end
    while (exp_q.size() > 0 && cycles < 200) begin
      cycles++;
      rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 3 == 1) : 1'($urandom_range(0, 1));
      if (flip && cycles == 5) halted = ~halted;
      pulses += int'(pulse);
      if (get_param !== dump) gp_bad = 1;
      if (cmd_ready !== 1'b0) rdy_bad = 1;
      if (prev_stall && (rsp_valid !== 1'b1 || rsp_data !== pd || rsp_last !== pl)) stab_bad = 1;
      prev_stall = rsp_valid && !rsp_ready;
      pd = rsp_data; pl = rsp_last;
      if (rsp_valid && rsp_ready) begin
        w = exp_q.pop_front();
        total++;
        if (rsp_data !== w || rsp_last !== (exp_q.size() == 0)) begin
          bad++;
          $display("FAIL word op%0d #%0d: got %h last=%b, required %h last=%b", op, n, rsp_data, rsp_last, w, exp_q.size() == 0);
        end
        n++;
      end
      @(negedge clock);
    end
    rsp_ready = 0;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL timeout op%0d: %0d words missing, required 0", op, exp_q.size()); end
    total++;
    if (pulses != exp_pulses) begin bad++; $display("FAIL pulses op%0d: got %0d, required %0d", op, pulses, exp_pulses); end
    total++;
    if (gp_bad) begin bad++; $display("FAIL get_param op%0d: deviated, required %b throughout", op, dump); end
    total++;
    if (rdy_bad) begin bad++; $display("FAIL cmd_ready_busy op%0d: got 1 while busy, required 0", op); end
    total++;
    if (stab_bad) begin bad++; $display("FAIL stall_hold op%0d: word changed while stalled, required stable", op); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_after op%0d: got %b, required 1", op, cmd_ready); end
    if (exp_pulses == 1 && cont_cnt < (1 << W) - 1) cont_cnt++;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clock);
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_last, pulse, get_param, reg_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b v=%b d=%h l=%b p=%b gp=%b a=%h, required all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_last, pulse, get_param, reg_addr);
    end
    reset = 1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release: got %b, required 0", cmd_ready); end
    @(negedge clock);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b, required 1", cmd_ready); end
    cont_cnt = 0;
  endtask

  task automatic test_dump_halted;
    int cyc;
    for (int i = 0; i < 8; i++) regs[i] = W'(i + 1);
    regs[8] = W'('h123);
    halted = 1;
    run_cmd(2'd2, 0, 0, cyc);
    total++;
    if (cyc != 18) begin bad++; $display("FAIL dump_latency: got %0d cycles, required 18", cyc); end
  endtask

  task automatic test_dump_running;
    int cyc;
    halted = 0;
    run_cmd(2'd2, 0, 0, cyc);
  endtask

  task automatic test_continue;
    int cyc;
    halted = 1;
    run_cmd(2'd3, 0, 0, cyc);
    halted = 0;
    run_cmd(2'd3, 0, 0, cyc);
  endtask

  task automatic test_status_nop;
    int cyc;
    halted = 1;
    run_cmd(2'd1, 0, 0, cyc);
    halted = 0;
    run_cmd(2'd1, 1, 0, cyc);
    run_cmd(2'd0, 0, 0, cyc);
  endtask

  task automatic test_dump_stall;
    int cyc;
    for (int i = 0; i < 9; i++) regs[i] = W'($urandom);
    halted = 1;
    run_cmd(2'd2, 1, 1, cyc);
  endtask

  task automatic test_reset_mid_dump;
    int cyc;
    for (int i = 0; i < 9; i++) regs[i] = W'($urandom);
    halted = 1;
    while (!cmd_ready) @(negedge clock);
    cmd_valid = 1; cmd_op = 2'd2;
    @(negedge clock);
    cmd_valid = 0;
    for (int c = 1; c < 8; c++) begin rsp_ready = 1; @(negedge clock); end
    rsp_ready = 0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== regs[3]) begin
      bad++;
      $display("FAIL fourth_word: got v=%b %h, required v=1 %h", rsp_valid, rsp_data, regs[3]);
    end
    reset = 0;
    #1;
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_last, pulse, get_param, reg_addr} !== '0) begin
      bad++;
      $display("FAIL reset_mid_dump: rdy=%b v=%b d=%h l=%b p=%b gp=%b a=%h, required all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_last, pulse, get_param, reg_addr);
    end
    @(negedge clock);
    reset = 1;
    cont_cnt = 0;
    @(negedge clock);
    run_cmd(2'd1, 0, 0, cyc);
  endtask

  task automatic test_counter;
    int cyc;
    halted = 1;
    for (int i = 0; i < 3; i++) run_cmd(2'd3, 2, 0, cyc);
    run_cmd(2'd1, 0, 0, cyc);
  endtask

  task automatic test_random;
    int cyc;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) for (int i = 0; i < 9; i++) regs[i] = W'($urandom);
      halted = 1'($urandom_range(0, 1));
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) regs[i] = '0;
    @(negedge clock);
    test_reset;
    test_status_nop;
    test_dump_halted;
    test_dump_running;
    test_continue;
    test_dump_stall;
    test_reset_mid_dump;
    test_counter;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
